// File: rtl/dp_lt_pkg.sv
// Shared definitions for the DPCD link-training responder: AUX command
// encodings, DPCD register addresses, FSM state and response type enums,
// and the lane-count to active-lane mask helper.
package dp_lt_pkg;

    localparam logic [1:0] AUX_CMD_WR = 2'b00;
    localparam logic [1:0] AUX_CMD_RD = 2'b01;

    localparam logic [19:0] DPCD_LINK_BW_SET    = 20'h00100;
    localparam logic [19:0] DPCD_LANE_COUNT_SET = 20'h00101;
    localparam logic [19:0] DPCD_TPS_SET        = 20'h00102;
    localparam logic [19:0] DPCD_LANE0_SET      = 20'h00103;
    localparam logic [19:0] DPCD_LANE1_SET      = 20'h00104;
    localparam logic [19:0] DPCD_LANE2_SET      = 20'h00105;
    localparam logic [19:0] DPCD_LANE3_SET      = 20'h00106;
    localparam logic [19:0] DPCD_LANE01_STATUS  = 20'h00202;
    localparam logic [19:0] DPCD_LANE23_STATUS  = 20'h00203;
    localparam logic [19:0] DPCD_ALIGN_STATUS   = 20'h00204;
    localparam logic [19:0] DPCD_ADJ_LANE01     = 20'h00206;
    localparam logic [19:0] DPCD_ADJ_LANE23     = 20'h00207;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_DATA  = 3'd1,
        ST_RD_SNAP  = 3'd2,
        ST_RSP_WAIT = 3'd3,
        ST_RSP      = 3'd4,
        ST_RD_DATA  = 3'd5
    } lt_state_e;

    typedef enum logic [1:0] {
        RSP_ACK   = 2'd0,
        RSP_NACK  = 2'd1,
        RSP_DEFER = 2'd2
    } rsp_type_e;

    // Only 1, 2 and 4 lanes are legal; anything else behaves as one lane.
    function automatic logic [3:0] lane_mask(input logic [4:0] lane_count);
        logic [3:0] mask;
        case (lane_count)
            5'd2:    mask = 4'b0011;
            5'd4:    mask = 4'b1111;
            default: mask = 4'b0001;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dpcd_lt_responder_if.sv
// AUX-side request/response bundle of the DPCD link-training responder.
// master = requester (drives req_*), slave = responder (drives rsp_*, busy).
interface dpcd_lt_responder_if;
    logic        req_vld;
    logic [1:0]  req_cmd;
    logic [19:0] req_address;
    logic [7:0]  req_len;
    logic [7:0]  req_data;
    logic        req_data_vld;
    logic        rsp_vld;
    logic        rsp_ack;
    logic        rsp_nack;
    logic        rsp_defer;
    logic [7:0]  rsp_data;
    logic        rsp_data_vld;
    logic        busy;

    modport master (
        output req_vld, req_cmd, req_address, req_len, req_data, req_data_vld,
        input  rsp_vld, rsp_ack, rsp_nack, rsp_defer, rsp_data, rsp_data_vld, busy
    );

    modport slave (
        input  req_vld, req_cmd, req_address, req_len, req_data, req_data_vld,
        output rsp_vld, rsp_ack, rsp_nack, rsp_defer, rsp_data, rsp_data_vld, busy
    );
endinterface

// File: rtl/dpcd_lt_regfile.sv
// DPCD register map: link-training configuration registers written by the
// host, a one-shot snapshot of the sink status, and the read mux that serves
// every byte of a read from that snapshot.
module dpcd_lt_regfile
    import dp_lt_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [19:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_hit,
    input  logic        snap_en,
    input  logic [3:0]  sink_cr_done,
    input  logic [3:0]  sink_channel_eq,
    input  logic [3:0]  sink_symbol_lock,
    input  logic        sink_lane_align,
    input  logic [7:0]  sink_adj_vtg,
    input  logic [7:0]  sink_adj_pre,
    input  logic [19:0] rd_addr,
    output logic [7:0]  rd_data,
    output logic [7:0]  link_bw_set,
    output logic [4:0]  lane_count_set,
    output logic [1:0]  tps_set,
    output logic [7:0]  lane_vtg,
    output logic [7:0]  lane_pre
);

    logic [7:0] link_bw_r;
    logic [4:0] lane_count_r;
    logic [1:0] tps_r;
    logic [7:0] vtg_r;
    logic [7:0] pre_r;
    logic [3:0] snap_cr_r;
    logic [3:0] snap_eq_r;
    logic [3:0] snap_lock_r;
    logic       snap_align_r;
    logic [7:0] snap_vtg_r;
    logic [7:0] snap_pre_r;
    logic [3:0] mask_s;
    logic [2:0] stat_s [4];
    logic [7:0] rd_data_s;

    assign wr_hit = (wr_addr >= DPCD_LINK_BW_SET) && (wr_addr <= DPCD_LANE3_SET);

    // Configuration register write decode; unmapped addresses are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_bw_r    <= 8'h00;
            lane_count_r <= 5'd0;
            tps_r        <= 2'd0;
            vtg_r        <= 8'h00;
            pre_r        <= 8'h00;
        end else if (wr_en) begin
            case (wr_addr)
                DPCD_LINK_BW_SET:    link_bw_r    <= wr_data;
                DPCD_LANE_COUNT_SET: lane_count_r <= wr_data[4:0];
                DPCD_TPS_SET:        tps_r        <= wr_data[1:0];
                DPCD_LANE0_SET: begin vtg_r[1:0] <= wr_data[1:0]; pre_r[1:0] <= wr_data[4:3]; end
                DPCD_LANE1_SET: begin vtg_r[3:2] <= wr_data[1:0]; pre_r[3:2] <= wr_data[4:3]; end
                DPCD_LANE2_SET: begin vtg_r[5:4] <= wr_data[1:0]; pre_r[5:4] <= wr_data[4:3]; end
                DPCD_LANE3_SET: begin vtg_r[7:6] <= wr_data[1:0]; pre_r[7:6] <= wr_data[4:3]; end
                default: begin end
            endcase
        end
    end

    // Sink status snapshot, taken once per read so all bytes are coherent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_cr_r    <= 4'h0;
            snap_eq_r    <= 4'h0;
            snap_lock_r  <= 4'h0;
            snap_align_r <= 1'b0;
            snap_vtg_r   <= 8'h00;
            snap_pre_r   <= 8'h00;
        end else if (snap_en) begin
            snap_cr_r    <= sink_cr_done;
            snap_eq_r    <= sink_channel_eq;
            snap_lock_r  <= sink_symbol_lock;
            snap_align_r <= sink_lane_align;
            snap_vtg_r   <= sink_adj_vtg;
            snap_pre_r   <= sink_adj_pre;
        end
    end

    // Read mux; per-lane status of inactive lanes is forced to zero.
    always_comb begin
        rd_data_s = 8'h00;
        mask_s    = lane_mask(lane_count_r);
        for (int i = 0; i < 4; i++) begin
            stat_s[i] = {snap_lock_r[i], snap_eq_r[i], snap_cr_r[i]} & {3{mask_s[i]}};
        end
        case (rd_addr)
            DPCD_LINK_BW_SET:    rd_data_s = link_bw_r;
            DPCD_LANE_COUNT_SET: rd_data_s = {3'b000, lane_count_r};
            DPCD_TPS_SET:        rd_data_s = {6'b000000, tps_r};
            DPCD_LANE0_SET:      rd_data_s = {3'b000, pre_r[1:0], 1'b0, vtg_r[1:0]};
            DPCD_LANE1_SET:      rd_data_s = {3'b000, pre_r[3:2], 1'b0, vtg_r[3:2]};
            DPCD_LANE2_SET:      rd_data_s = {3'b000, pre_r[5:4], 1'b0, vtg_r[5:4]};
            DPCD_LANE3_SET:      rd_data_s = {3'b000, pre_r[7:6], 1'b0, vtg_r[7:6]};
            DPCD_LANE01_STATUS:  rd_data_s = {1'b0, stat_s[1], 1'b0, stat_s[0]};
            DPCD_LANE23_STATUS:  rd_data_s = {1'b0, stat_s[3], 1'b0, stat_s[2]};
            DPCD_ALIGN_STATUS:   rd_data_s = {7'b0000000, snap_align_r};
            DPCD_ADJ_LANE01:     rd_data_s = {snap_pre_r[3:2], snap_vtg_r[3:2], snap_pre_r[1:0], snap_vtg_r[1:0]};
            DPCD_ADJ_LANE23:     rd_data_s = {snap_pre_r[7:6], snap_vtg_r[7:6], snap_pre_r[5:4], snap_vtg_r[5:4]};
            default:             rd_data_s = 8'h00;
        endcase
    end

    assign rd_data        = rd_data_s;
    assign link_bw_set    = link_bw_r;
    assign lane_count_set = lane_count_r;
    assign tps_set        = tps_r;
    assign lane_vtg       = vtg_r;
    assign lane_pre       = pre_r;

endmodule

// File: rtl/dpcd_lt_responder.sv
// DPCD link-training responder: services AUX native reads/writes against the
// link-training register map with a fixed response delay.
// Optional feature macro: DPCD_LT_RSP_DEFER_EN (DEFER replies while sink_busy).
// RSP_DLY is expected to be at least 1.
module dpcd_lt_responder
    import dp_lt_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int RSP_DLY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    dpcd_lt_responder_if.slave bus,
    input  logic [3:0]         sink_cr_done,
    input  logic [3:0]         sink_channel_eq,
    input  logic [3:0]         sink_symbol_lock,
    input  logic               sink_lane_align,
    input  logic [7:0]         sink_adj_vtg,
    input  logic [7:0]         sink_adj_pre,
    input  logic               sink_busy,
    output logic [7:0]         link_bw_set,
    output logic [4:0]         lane_count_set,
    output logic [1:0]         tps_set,
    output logic [7:0]         lane_vtg,
    output logic [7:0]         lane_pre,
    output logic               config_upd
);

    localparam logic [7:0] DLY_LAST = (RSP_DLY < 1) ? 8'd0 : 8'(RSP_DLY - 1);

    lt_state_e   state_r, state_next_s;
    logic [1:0]  cmd_r, cmd_next_s;
    logic [19:0] addr_r, addr_next_s;
    logic [7:0]  len_r, len_next_s;
    logic [7:0]  cnt_r, cnt_next_s;
    logic [7:0]  dly_r, dly_next_s;
    rsp_type_e   rsp_type_r, rsp_type_next_s;
    logic        drop_r, drop_next_s;
    logic        touch_r, touch_next_s;
    logic        wr_en_s, wr_hit_s, snap_en_s, too_long_s;
    logic [7:0]  rd_data_s, rd_byte_next_s;
    logic        rsp_vld_r, rsp_ack_r, rsp_nack_r, rsp_data_vld_r, busy_r, config_upd_r;
    logic [7:0]  rsp_data_r;

    assign too_long_s = ({24'd0, bus.req_len} + 32'd1) > 32'(MAX_LEN);

    dpcd_lt_regfile u_regfile (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_en            (wr_en_s),
        .wr_addr          (addr_r),
        .wr_data          (bus.req_data),
        .wr_hit           (wr_hit_s),
        .snap_en          (snap_en_s),
        .sink_cr_done     (sink_cr_done),
        .sink_channel_eq  (sink_channel_eq),
        .sink_symbol_lock (sink_symbol_lock),
        .sink_lane_align  (sink_lane_align),
        .sink_adj_vtg     (sink_adj_vtg),
        .sink_adj_pre     (sink_adj_pre),
        .rd_addr          (addr_r),
        .rd_data          (rd_data_s),
        .link_bw_set      (link_bw_set),
        .lane_count_set   (lane_count_set),
        .tps_set          (tps_set),
        .lane_vtg         (lane_vtg),
        .lane_pre         (lane_pre)
    );

    // FSM state and request context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cmd_r      <= 2'b00;
            addr_r     <= 20'h00000;
            len_r      <= 8'h00;
            cnt_r      <= 8'h00;
            dly_r      <= 8'h00;
            rsp_type_r <= RSP_ACK;
            drop_r     <= 1'b0;
            touch_r    <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cmd_r      <= cmd_next_s;
            addr_r     <= addr_next_s;
            len_r      <= len_next_s;
            cnt_r      <= cnt_next_s;
            dly_r      <= dly_next_s;
            rsp_type_r <= rsp_type_next_s;
            drop_r     <= drop_next_s;
            touch_r    <= touch_next_s;
        end
    end

    // Next-state and datapath control for the request/response sequence.
    always_comb begin
        state_next_s    = state_r;
        cmd_next_s      = cmd_r;
        addr_next_s     = addr_r;
        len_next_s      = len_r;
        cnt_next_s      = cnt_r;
        dly_next_s      = dly_r;
        rsp_type_next_s = rsp_type_r;
        drop_next_s     = drop_r;
        touch_next_s    = touch_r;
        wr_en_s         = 1'b0;
        snap_en_s       = 1'b0;
        rd_byte_next_s  = 8'h00;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_vld) begin
                    cmd_next_s      = bus.req_cmd;
                    addr_next_s     = bus.req_address;
                    len_next_s      = bus.req_len;
                    cnt_next_s      = 8'h00;
                    dly_next_s      = 8'h00;
                    touch_next_s    = 1'b0;
                    drop_next_s     = 1'b0;
                    rsp_type_next_s = RSP_ACK;
                    if (bus.req_cmd[1]) begin
                        rsp_type_next_s = RSP_NACK;
                        state_next_s    = ST_RSP_WAIT;
`ifdef DPCD_LT_RSP_DEFER_EN
                    end else if (sink_busy) begin
                        rsp_type_next_s = RSP_DEFER;
                        drop_next_s     = 1'b1;
                        state_next_s    = (bus.req_cmd == AUX_CMD_WR) ? ST_WR_DATA : ST_RSP_WAIT;
`endif
                    end else if (too_long_s) begin
                        rsp_type_next_s = RSP_NACK;
                        drop_next_s     = 1'b1;
                        state_next_s    = (bus.req_cmd == AUX_CMD_WR) ? ST_WR_DATA : ST_RSP_WAIT;
                    end else if (bus.req_cmd == AUX_CMD_WR) begin
                        state_next_s = ST_WR_DATA;
                    end else begin
                        state_next_s = ST_RD_SNAP;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                if (bus.req_data_vld) begin
                    wr_en_s      = !drop_r;
                    touch_next_s = touch_r | (!drop_r & wr_hit_s);
                    addr_next_s  = addr_r + 20'd1;
                    cnt_next_s   = cnt_r + 8'd1;
                    if (cnt_r == len_r) begin
                        state_next_s = ST_RSP_WAIT;
                    end else begin
                        state_next_s = ST_WR_DATA;
                    end
                end else begin
                    state_next_s = ST_WR_DATA;
                end
            end
            ST_RD_SNAP: begin
                snap_en_s    = 1'b1;
                dly_next_s   = 8'h00;
                state_next_s = ST_RSP_WAIT;
            end
            ST_RSP_WAIT: begin
                if (dly_r == DLY_LAST) begin
                    state_next_s = ST_RSP;
                end else begin
                    dly_next_s   = dly_r + 8'd1;
                    state_next_s = ST_RSP_WAIT;
                end
            end
            ST_RSP: begin
                if ((rsp_type_r == RSP_ACK) && (cmd_r == AUX_CMD_RD)) begin
                    rd_byte_next_s = rd_data_s;
                    addr_next_s    = addr_r + 20'd1;
                    cnt_next_s     = 8'h00;
                    state_next_s   = ST_RD_DATA;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RD_DATA: begin
                if (cnt_r == len_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    rd_byte_next_s = rd_data_s;
                    addr_next_s    = addr_r + 20'd1;
                    cnt_next_s     = cnt_r + 8'd1;
                    state_next_s   = ST_RD_DATA;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Registered response, read stream and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_r      <= 1'b0;
            rsp_ack_r      <= 1'b0;
            rsp_nack_r     <= 1'b0;
            rsp_data_r     <= 8'h00;
            rsp_data_vld_r <= 1'b0;
            busy_r         <= 1'b0;
            config_upd_r   <= 1'b0;
        end else begin
            rsp_vld_r      <= (state_next_s == ST_RSP);
            rsp_ack_r      <= (state_next_s == ST_RSP) && (rsp_type_next_s == RSP_ACK);
            rsp_nack_r     <= (state_next_s == ST_RSP) && (rsp_type_next_s == RSP_NACK);
            rsp_data_r     <= rd_byte_next_s;
            rsp_data_vld_r <= (state_next_s == ST_RD_DATA);
            busy_r         <= (state_next_s != ST_IDLE);
            config_upd_r   <= (state_next_s == ST_RSP) && (rsp_type_next_s == RSP_ACK) && touch_next_s;
        end
    end

`ifdef DPCD_LT_RSP_DEFER_EN
    logic rsp_defer_r;

    // Registered DEFER flag, pulsed alongside rsp_vld.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_defer_r <= 1'b0;
        end else begin
            rsp_defer_r <= (state_next_s == ST_RSP) && (rsp_type_next_s == RSP_DEFER);
        end
    end

    assign bus.rsp_defer = rsp_defer_r;
`else
    logic sink_busy_unused_s;
    assign sink_busy_unused_s = sink_busy;
    assign bus.rsp_defer      = 1'b0;
`endif

    assign bus.rsp_vld      = rsp_vld_r;
    assign bus.rsp_ack      = rsp_ack_r;
    assign bus.rsp_nack     = rsp_nack_r;
    assign bus.rsp_data     = rsp_data_r;
    assign bus.rsp_data_vld = rsp_data_vld_r;
    assign bus.busy         = busy_r;
    assign config_upd       = config_upd_r;

endmodule

// File: tb/tb_dpcd_lt_responder.sv
// Directed self-checking bench for dpcd_lt_responder (MAX_LEN=16, RSP_DLY=2).
// Inputs are driven and outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_dpcd_lt_responder;
    import dp_lt_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sink_cr_done, sink_channel_eq, sink_symbol_lock;
    logic       sink_lane_align, sink_busy;
    logic [7:0] sink_adj_vtg, sink_adj_pre;
    logic [7:0] link_bw_set, lane_vtg, lane_pre;
    logic [4:0] lane_count_set;
    logic [1:0] tps_set;
    logic       config_upd;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] wbuf [0:31];
    logic [7:0] rbuf [0:31];
    int         rcnt, rfirst, rlast, lat, npulse;
    logic [3:0] flags;

    always #5 clk = ~clk;

    dpcd_lt_responder_if bus ();

    dpcd_lt_responder #(.MAX_LEN(16), .RSP_DLY(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .sink_cr_done     (sink_cr_done),
        .sink_channel_eq  (sink_channel_eq),
        .sink_symbol_lock (sink_symbol_lock),
        .sink_lane_align  (sink_lane_align),
        .sink_adj_vtg     (sink_adj_vtg),
        .sink_adj_pre     (sink_adj_pre),
        .sink_busy        (sink_busy),
        .link_bw_set      (link_bw_set),
        .lane_count_set   (lane_count_set),
        .tps_set          (tps_set),
        .lane_vtg         (lane_vtg),
        .lane_pre         (lane_pre),
        .config_upd       (config_upd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Header cycle, then n bytes from wbuf; optional two-cycle gap before byte gap_at
    // with a stray read request raised while the block is busy.
    task automatic do_write(input logic [19:0] a, input int n, input int gap_at);
        @(negedge clk);
        bus.req_vld = 1'b1; bus.req_cmd = AUX_CMD_WR; bus.req_address = a; bus.req_len = 8'(n - 1);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                @(negedge clk);
                bus.req_data_vld = 1'b0; bus.req_vld = 1'b1; bus.req_cmd = AUX_CMD_RD;
                chk("busy_in_gap", 32'(bus.busy), 32'd1);
                @(negedge clk);
                bus.req_vld = 1'b0;
            end
            @(negedge clk);
            bus.req_vld = 1'b0; bus.req_data = wbuf[i]; bus.req_data_vld = 1'b1;
        end
    endtask

    task automatic send_req(input logic [1:0] cmd, input logic [19:0] a, input logic [7:0] len);
        @(negedge clk);
        bus.req_vld = 1'b1; bus.req_cmd = cmd; bus.req_address = a; bus.req_len = len;
    endtask

    // Bounded wait for rsp_vld; lat counts falling edges after the last driven cycle.
    task automatic wait_rsp(output int l, output logic [3:0] f);
        bit done = 1'b0;
        l = 0; f = 4'h0;
        while (!done && l < 30) begin
            @(negedge clk);
            bus.req_vld = 1'b0; bus.req_data_vld = 1'b0;
            l++;
            if (bus.rsp_vld === 1'b1) begin
                f = {config_upd, bus.rsp_defer, bus.rsp_nack, bus.rsp_ack};
                done = 1'b1;
            end
        end
        if (!done) l = -1;
    endtask

    task automatic collect();
        rcnt = 0; rfirst = -1; rlast = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.rsp_data_vld === 1'b1) begin
                if (rfirst < 0) rfirst = i;
                rlast = i;
                if (rcnt < 32) rbuf[rcnt] = bus.rsp_data;
                rcnt++;
            end
        end
    endtask

    initial begin
        bus.req_vld = 1'b0; bus.req_cmd = 2'b00; bus.req_address = 20'h0; bus.req_len = 8'h0;
        bus.req_data = 8'h0; bus.req_data_vld = 1'b0;
        sink_cr_done = 4'h0; sink_channel_eq = 4'h0; sink_symbol_lock = 4'h0;
        sink_lane_align = 1'b0; sink_adj_vtg = 8'h0; sink_adj_pre = 8'h0; sink_busy = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
        chk("rst_cfg", {8'h0, link_bw_set, 3'b0, lane_count_set, 6'b0, tps_set}, 32'd0);
        chk("rst_lane", {16'h0, lane_vtg, lane_pre}, 32'd0);
        rst_n = 1'b1;

        // Write link_bw / lane_count
        wbuf[0] = 8'h0A; wbuf[1] = 8'h04;
        do_write(20'h00100, 2, -1);
        wait_rsp(lat, flags);
        chk("wr100_lat", 32'(lat), 32'd3);
        chk("wr100_flags", 32'(flags), 32'h9);
        @(negedge clk);
        chk("wr100_single_pulse", {30'd0, bus.rsp_vld, config_upd}, 32'd0);
        chk("link_bw", 32'(link_bw_set), 32'h0A);
        chk("lane_count", 32'(lane_count_set), 32'd4);

        // Readback of config registers
        send_req(AUX_CMD_RD, 20'h00100, 8'd2);
        wait_rsp(lat, flags);
        chk("rd100_lat", 32'(lat), 32'd4);
        chk("rd100_flags", 32'(flags), 32'h1);
        collect();
        chk("rd100_cnt", 32'(rcnt), 32'd3);
        chk("rd100_first", 32'(rfirst), 32'd1);
        chk("rd100_bytes", {8'h0, rbuf[0], rbuf[1], rbuf[2]}, 32'h000A0400);

        // Two lanes, status read with snapshot coherence
        wbuf[0] = 8'h02;
        do_write(20'h00101, 1, -1);
        wait_rsp(lat, flags);
        chk("wr101_flags", 32'(flags), 32'h9);
        sink_cr_done = 4'hF; sink_symbol_lock = 4'hF; sink_channel_eq = 4'h0;
        send_req(AUX_CMD_RD, 20'h00202, 8'd1);
        wait_rsp(lat, flags);
        chk("rd202_flags", 32'(flags), 32'h1);
        sink_cr_done = 4'h0; sink_symbol_lock = 4'h0;
        collect();
        chk("rd202_cnt", 32'(rcnt), 32'd2);
        chk("rd202_contig", 32'(rlast - rfirst + 1), 32'd2);
        chk("rd202_bytes", {16'h0, rbuf[0], rbuf[1]}, 32'h5500);

        // Lane settings with a payload gap and a stray request while busy
        for (int i = 0; i < 4; i++) wbuf[i] = 8'h19;
        do_write(20'h00103, 4, 2);
        wait_rsp(lat, flags);
        chk("wr103_lat", 32'(lat), 32'd3);
        chk("wr103_flags", 32'(flags), 32'h9);
        chk("wr103_vtg_pre", {16'h0, lane_vtg, lane_pre}, 32'h55FF);
        chk("wr103_lane_count", 32'(lane_count_set), 32'd2);

        // Adjust request bytes
        sink_adj_vtg = 8'hE4; sink_adj_pre = 8'h1B;
        send_req(AUX_CMD_RD, 20'h00206, 8'd1);
        wait_rsp(lat, flags);
        collect();
        chk("rd206_bytes", {16'h0, rbuf[0], rbuf[1]}, 32'h9C36);

        // Illegal lane count behaves as one lane
        wbuf[0] = 8'h03;
        do_write(20'h00101, 1, -1);
        wait_rsp(lat, flags);
        sink_cr_done = 4'hF; sink_channel_eq = 4'hF; sink_symbol_lock = 4'hF; sink_lane_align = 1'b1;
        send_req(AUX_CMD_RD, 20'h00202, 8'd2);
        wait_rsp(lat, flags);
        collect();
        chk("rd202_lc3_bytes", {8'h0, rbuf[0], rbuf[1], rbuf[2]}, 32'h00070001);

        // Largest legal read: 16 bytes from unmapped space
        send_req(AUX_CMD_RD, 20'h00300, 8'd15);
        wait_rsp(lat, flags);
        chk("rd16_flags", 32'(flags), 32'h1);
        collect();
        chk("rd16_cnt", 32'(rcnt), 32'd16);
        chk("rd16_contig", 32'(rlast - rfirst + 1), 32'd16);
        chk("rd16_zero", {24'h0, rbuf[0] | rbuf[7] | rbuf[15]}, 32'd0);

        // Oversized read -> NACK, no data
        send_req(AUX_CMD_RD, 20'h00202, 8'd16);
        wait_rsp(lat, flags);
        chk("rd17_flags", 32'(flags), 32'h2);
        collect();
        chk("rd17_nodata", 32'(rcnt), 32'd0);

        // Invalid command -> NACK
        send_req(2'b10, 20'h00100, 8'd0);
        wait_rsp(lat, flags);
        chk("badcmd_lat", 32'(lat), 32'd3);
        chk("badcmd_flags", 32'(flags), 32'h2);

        // Oversized write -> payload consumed, NACK, no change
        for (int i = 0; i < 17; i++) wbuf[i] = 8'h03;
        do_write(20'h00102, 17, -1);
        wait_rsp(lat, flags);
        chk("wr17_lat", 32'(lat), 32'd3);
        chk("wr17_flags", 32'(flags), 32'h2);
        chk("wr17_tps", 32'(tps_set), 32'd0);

        // Stray payload while idle is ignored
        @(negedge clk);
        bus.req_data = 8'h02; bus.req_data_vld = 1'b1;
        repeat (2) @(negedge clk);
        bus.req_data_vld = 1'b0;
        chk("stray_busy", 32'(bus.busy), 32'd0);
        chk("stray_tps", 32'(tps_set), 32'd0);

        // Unmapped write is ACKed without config_upd
        wbuf[0] = 8'hAA;
        do_write(20'h00500, 1, -1);
        wait_rsp(lat, flags);
        chk("wr500_flags", 32'(flags), 32'h1);

        // Last mapped address then unmapped 0x107
        wbuf[0] = 8'h02; wbuf[1] = 8'h07;
        do_write(20'h00106, 2, -1);
        wait_rsp(lat, flags);
        chk("wr106_flags", 32'(flags), 32'h9);
        chk("wr106_vtg_pre", {16'h0, lane_vtg, lane_pre}, 32'h953F);

        // Reset in the middle of a write payload
        wbuf[0] = 8'h02; wbuf[1] = 8'h02;
        do_write(20'h00102, 1, -1);
        @(negedge clk);
        send_req(AUX_CMD_WR, 20'h00102, 8'd1);
        @(negedge clk);
        bus.req_vld = 1'b0; bus.req_data = 8'h02; bus.req_data_vld = 1'b1;
        @(negedge clk);
        bus.req_data_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_cfg", {8'h0, link_bw_set, 3'b0, lane_count_set, 6'b0, tps_set}, 32'd0);
        chk("abort_lane", {16'h0, lane_vtg, lane_pre}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        npulse = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.rsp_vld === 1'b1) npulse++;
        end
        chk("abort_no_rsp", 32'(npulse), 32'd0);
        wbuf[0] = 8'h01;
        do_write(20'h00102, 1, -1);
        wait_rsp(lat, flags);
        chk("post_rst_lat", 32'(lat), 32'd3);
        chk("post_rst_flags", 32'(flags), 32'h9);
        chk("post_rst_tps", 32'(tps_set), 32'd1);

        // sink_busy during a write
        sink_busy = 1'b1;
        wbuf[0] = 8'h03;
        do_write(20'h00102, 1, -1);
        wait_rsp(lat, flags);
        chk("busy_wr_lat", 32'(lat), 32'd3);
`ifdef DPCD_LT_RSP_DEFER_EN
        chk("busy_wr_flags", 32'(flags), 32'h4);
        chk("busy_wr_tps", 32'(tps_set), 32'd1);
`else
        chk("busy_wr_flags", 32'(flags), 32'h9);
        chk("busy_wr_tps", 32'(tps_set), 32'd3);
`endif
        sink_busy = 1'b0;

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dpcd_lt_responder.md
DPCD_LT_RESPONDER -- requirements
Module: dpcd_lt_responder

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16: maximum bytes per request (len+1); larger requests are NACKed.
REQ-002 SHALL have parameter RSP_DLY, default 2: idle cycles between the end of a request and rsp_vld.
REQ-003 SHALL have port clk  in  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_vld  in  1  request strobe with cmd, address and len; sampled only in IDLE.
REQ-006 SHALL have port req_cmd  in  2  00 native write, 01 native read, 1x invalid.
REQ-007 SHALL have port req_address  in  20  DPCD start address.
REQ-008 SHALL have port req_len  in  8  byte count minus one.
REQ-009 SHALL have ports req_data/req_data_vld  in  8/1  write payload, one byte per valid cycle, gaps allowed.
REQ-010 SHALL have ports sink_cr_done, sink_channel_eq, sink_symbol_lock  in  4 each  per-lane sink status.
REQ-011 SHALL have ports sink_lane_align  in  1, and sink_adj_vtg/sink_adj_pre  in  8 each (2 bits per lane).
REQ-012 SHALL have port sink_busy  in  1  sink not ready; used only under the macro in REQ-031.
REQ-013 SHALL have ports rsp_vld, rsp_ack, rsp_nack, rsp_defer  out  1 each  one-cycle response pulse with its type.
REQ-014 SHALL have ports rsp_data/rsp_data_vld  out  8/1  read payload stream.
REQ-015 SHALL have ports busy  out  1; link_bw_set  out  8; lane_count_set  out  5; tps_set  out  2; lane_vtg/lane_pre  out  8 each; config_upd  out  1.

Function
REQ-016 SHALL implement FSM IDLE -> (WR_DATA | RD_SNAP) -> RSP_WAIT -> RSP -> (RD_DATA | IDLE); busy SHALL be high in every state except IDLE.
REQ-017 In IDLE with req_vld, SHALL capture cmd, address and len in the same cycle; an invalid cmd SHALL go to RSP_WAIT and return NACK.
REQ-018 WR_DATA SHALL accept exactly len+1 bytes, auto-incrementing a 20-bit address that wraps 0xFFFFF->0x00000, then enter RSP_WAIT.
REQ-019 SHALL apply the write map: 0x00100 link_bw_set; 0x00101 lane_count_set = bits[4:0]; 0x00102 tps_set = bits[1:0]; 0x00103-0x00106 lane n vtg = bits[1:0], pre = bits[4:3].
REQ-020 Writes to unmapped addresses SHALL be dropped and still ACKed.
REQ-021 RD_SNAP SHALL register all sink_* inputs for one cycle; every byte returned by that read SHALL come from this snapshot.
REQ-022 SHALL apply the read map: 0x00202 lane0 {bit2 lock, bit1 eq, bit0 cr}, lane1 at bits 6:4; 0x00203 lanes 2/3 likewise.
REQ-023 Read map, continued: 0x00204 bit0 = sink_lane_align; 0x00206/0x00207 {pre1, vtg1, pre0, vtg0} per lane pair; 0x00100-0x00106 read back their registers; all other addresses return 0x00.
REQ-024 Status bits for lanes >= lane_count_set SHALL read 0; a lane_count_set value other than 1, 2 or 4 SHALL be treated as 1.
REQ-025 RSP_WAIT SHALL last exactly RSP_DLY cycles; RSP SHALL pulse rsp_vld for one cycle with exactly one of rsp_ack, rsp_nack or rsp_defer set.
REQ-026 For an ACKed read, RD_DATA SHALL begin the cycle after rsp_vld and emit len+1 consecutive rsp_data_vld cycles, with no gaps.
REQ-027 If len+1 > MAX_LEN, the block SHALL respond NACK; write payload is still consumed and discarded; no register is changed.
REQ-028 req_vld while busy, and req_data_vld outside WR_DATA, SHALL be ignored.
REQ-029 config_upd SHALL pulse for one cycle coincident with the ACK rsp_vld of any write touching 0x00100-0x00106.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, zero every output and register, and abort any request in progress; no response is issued for an aborted request.

Configuration
REQ-031 Macro DPCD_LT_RSP_DEFER_EN defined: sink_busy high when a request is captured SHALL produce DEFER after RSP_DLY, with no register access and write payload discarded. Macro undefined: sink_busy SHALL be ignored and rsp_defer SHALL be tied 0.

Structure
REQ-032 A shared package dp_lt_pkg SHALL hold the AUX cmd encodings, the DPCD address constants and the FSM state enum.
REQ-033 The DPCD register map SHALL be a sub-module dpcd_lt_regfile, covering write decode and snapshot read mux; the FSM stays in the top module.

Verification
REQ-034 Write 0x00100, len=1, data 0x0A,0x04 -> ACK RSP_DLY cycles after the last byte; link_bw_set=0x0A, lane_count_set=4, config_upd pulses once.
REQ-035 lane_count_set=2, cr_done=4'hF, lock=4'hF, read 0x00202 len=1 -> ACK, then bytes 0x55, 0x00.
REQ-036 Write 0x00103 len=3 with 0x19 each byte -> all four lanes vtg=1, pre=3.
REQ-037 Read len=16 with MAX_LEN=16 -> NACK, no rsp_data_vld; cmd=2'b10 -> NACK.
REQ-038 rst_n low mid-WR_DATA -> outputs 0, IDLE, no rsp_vld; the next request is serviced normally.
REQ-039 DPCD_LT_RSP_DEFER_EN defined, sink_busy=1, write 0x00102 -> DEFER, tps_set unchanged; macro undefined -> ACK.
